// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REPLAY   = 2'd2
    } ctrl_state_t;

    localparam int REG_ZERO        = 0;
    localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX/MEM status in, pipeline stall/nop controls out.
// PIPE_CTRL_PERF_EN adds the two performance counter outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W      = 16
`endif
);
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_use_rs1_i;
    logic                  id_use_rs2_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  ex_is_load_i;
    logic                  ex_redirect_i;
    logic                  mem_req_i;
    logic                  mem_ready_i;
    logic                  pc_stall_o;
    logic                  if_id_stall_o;
    logic                  if_id_nop_o;
    logic                  id_ex_nop_o;
    logic                  back_hold_o;
    logic                  mem_err_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0]      perf_stall_cnt_o;
    logic [CNT_W-1:0]      perf_flush_cnt_o;
`endif

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        output ex_rd_i, ex_is_load_i, ex_redirect_i, mem_req_i, mem_ready_i,
        input  pc_stall_o, if_id_stall_o, if_id_nop_o, id_ex_nop_o,
        input  back_hold_o, mem_err_o
`ifdef PIPE_CTRL_PERF_EN
        ,
        input  perf_stall_cnt_o, perf_flush_cnt_o
`endif
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        input  ex_rd_i, ex_is_load_i, ex_redirect_i, mem_req_i, mem_ready_i,
        output pc_stall_o, if_id_stall_o, if_id_nop_o, id_ex_nop_o,
        output back_hold_o, mem_err_o
`ifdef PIPE_CTRL_PERF_EN
        ,
        output perf_stall_cnt_o, perf_flush_cnt_o
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational compare of ID source registers against an in-flight destination;
// also usable for forwarding-path selection.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_valid,
    output logic                  hit
);
    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [1:0]            src_use;
    logic [1:0]            src_hit;

    assign src_addr[0] = rs1;
    assign src_addr[1] = rs2;
    assign src_use     = {use_rs2, use_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_addr[gi] == rd);
        end
    endgenerate

    // x0 is hardwired, so a write to it can never create a dependency
    assign hit = rd_valid && (rd != REG_ADDR_W'(REG_ZERO)) && (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, redirect flushes, and memory-wait holds with timeout.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    generate
        if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_illegal
        end
    endgenerate

    ctrl_state_t       state_reg, state_next;
    logic [WAIT_W-1:0] cnt_reg, cnt_next;
    logic              pend_reg, pend_next;
    logic              err_reg, err_next;
    logic              load_use;
    logic              pc_stall, if_id_stall, if_id_nop, id_ex_nop, back_hold;
    logic              redirect_flush;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .rs1      (bus.id_rs1_i),
        .rs2      (bus.id_rs2_i),
        .use_rs1  (bus.id_use_rs1_i),
        .use_rs2  (bus.id_use_rs2_i),
        .rd       (bus.ex_rd_i),
        .rd_valid (bus.ex_is_load_i),
        .hit      (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_next      = pend_reg;
        err_next       = err_reg;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_nop      = 1'b0;
        id_ex_nop      = 1'b0;
        back_hold      = 1'b0;
        redirect_flush = 1'b0;
        case (state_reg)
            RUN: begin
                // a same-cycle ready is a single-cycle access and does not stall
                if (bus.mem_req_i && !bus.mem_ready_i) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    back_hold   = 1'b1;
                    state_next  = MEM_WAIT;
                    cnt_next    = WAIT_W'(1);
                    if (bus.ex_redirect_i) pend_next = 1'b1;
                end else if (bus.ex_redirect_i) begin
                    if_id_nop      = 1'b1;
                    id_ex_nop      = 1'b1;
                    redirect_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_nop   = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                back_hold   = 1'b1;
                if (bus.ex_redirect_i) pend_next = 1'b1;
                if (bus.mem_ready_i) begin
                    state_next = REPLAY;
                end else if (cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = REPLAY;
                end else begin
                    cnt_next = cnt_reg + WAIT_W'(1);
                end
            end
            REPLAY: begin
                // a redirect deferred by the wait is honoured before new hazards
                state_next = RUN;
                pend_next  = 1'b0;
                if (pend_reg || bus.ex_redirect_i) begin
                    if_id_nop      = 1'b1;
                    id_ex_nop      = 1'b1;
                    redirect_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_nop   = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.pc_stall_o    = pc_stall;
    assign bus.if_id_stall_o = if_id_stall;
    assign bus.if_id_nop_o   = if_id_nop;
    assign bus.id_ex_nop_o   = id_ex_nop;
    assign bus.back_hold_o   = back_hold;
    assign bus.mem_err_o     = err_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_reg;
    logic [CNT_W-1:0] perf_flush_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (pc_stall && !(&perf_stall_reg))
                perf_stall_reg <= perf_stall_reg + CNT_W'(1);
            if (redirect_flush && !(&perf_flush_reg))
                perf_flush_reg <= perf_flush_reg + CNT_W'(1);
        end
    end

    assign bus.perf_stall_cnt_o = perf_stall_reg;
    assign bus.perf_flush_cnt_o = perf_flush_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int RW = 5;
    localparam int TO = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(
        .REG_ADDR_W(RW)
`ifdef PIPE_CTRL_PERF_EN
        , .CNT_W(CW)
`endif
    ) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hold_seen = 0;

    // model: wait length of the access in flight (0 = none), replay slot due, deferred redirect, sticky error
    int m_wait;
    bit m_replay, m_pend, m_err;
    longint m_stall_cnt, m_flush_cnt;
    bit e_pc, e_ifs, e_ifn, e_idn, e_hold, e_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_replay = 0; m_pend = 0; m_err = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic predict();
        bit lu;
        lu = bus.ex_is_load_i && (bus.ex_rd_i != 0) &&
             ((bus.id_use_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
              (bus.id_use_rs2_i && bus.id_rs2_i == bus.ex_rd_i));
        {e_pc, e_ifs, e_ifn, e_idn, e_hold, e_flush} = '0;
        if (m_wait > 0) begin
            {e_pc, e_ifs, e_hold} = 3'b111;
        end else if (!m_replay && bus.mem_req_i && !bus.mem_ready_i) begin
            {e_pc, e_ifs, e_hold} = 3'b111;
        end else if ((m_replay && m_pend) || bus.ex_redirect_i) begin
            {e_ifn, e_idn, e_flush} = 3'b111;
        end else if (lu) begin
            {e_pc, e_ifs, e_idn} = 3'b111;
        end
    endtask

    task automatic advance();
        if (e_pc) m_stall_cnt = (m_stall_cnt == (64'd1 << CW) - 1) ? m_stall_cnt : m_stall_cnt + 1;
        if (e_flush) m_flush_cnt = (m_flush_cnt == (64'd1 << CW) - 1) ? m_flush_cnt : m_flush_cnt + 1;
        if (m_wait > 0) begin
            if (bus.ex_redirect_i) m_pend = 1;
            if (bus.mem_ready_i) begin
                m_wait = 0; m_replay = 1;
            end else if (m_wait == TO) begin
                m_err = 1; m_wait = 0; m_replay = 1;
            end else begin
                m_wait++;
            end
        end else if (m_replay) begin
            m_replay = 0; m_pend = 0;
        end else if (bus.mem_req_i && !bus.mem_ready_i) begin
            m_wait = 1;
            if (bus.ex_redirect_i) m_pend = 1;
        end
    endtask

    task automatic cycle(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input bit u1, input bit u2, input logic [RW-1:0] rd,
                         input bit ld, input bit redir, input bit req, input bit rdy);
        @(negedge clk);
        bus.id_rs1_i = rs1; bus.id_rs2_i = rs2;
        bus.id_use_rs1_i = u1; bus.id_use_rs2_i = u2;
        bus.ex_rd_i = rd; bus.ex_is_load_i = ld; bus.ex_redirect_i = redir;
        bus.mem_req_i = req; bus.mem_ready_i = rdy;
        #1;
        predict();
        check("pc_stall", bus.pc_stall_o, e_pc);
        check("if_id_stall", bus.if_id_stall_o, e_ifs);
        check("if_id_nop", bus.if_id_nop_o, e_ifn);
        check("id_ex_nop", bus.id_ex_nop_o, e_idn);
        check("back_hold", bus.back_hold_o, e_hold);
        check("mem_err", bus.mem_err_o, m_err);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall", bus.perf_stall_cnt_o, m_stall_cnt[31:0]);
        check("perf_flush", bus.perf_flush_cnt_o, m_flush_cnt[31:0]);
`endif
        if (bus.back_hold_o === 1'b1) hold_seen++;
        $display("cyc %0d rs1=%0d rs2=%0d use=%b%b rd=%0d ld=%b redir=%b req=%b rdy=%b -> pc=%b ifs=%b ifn=%b idn=%b hold=%b err=%b",
                 cyc, rs1, rs2, u1, u2, rd, ld, redir, req, rdy, bus.pc_stall_o, bus.if_id_stall_o,
                 bus.if_id_nop_o, bus.id_ex_nop_o, bus.back_hold_o, bus.mem_err_o);
        @(posedge clk);
        advance();
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0;
        bus.ex_rd_i = '0; bus.ex_is_load_i = 0; bus.ex_redirect_i = 0;
        bus.mem_req_i = 0; bus.mem_ready_i = 0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check({tag, "_pc_stall"}, bus.pc_stall_o, 1'b0);
        check({tag, "_back_hold"}, bus.back_hold_o, 1'b0);
        check({tag, "_if_id_stall"}, bus.if_id_stall_o, 1'b0);
        check({tag, "_mem_err"}, bus.mem_err_o, 1'b0);
        model_reset();
        $display("reset %s applied at cycle %0d", tag, cyc);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_phase(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            cycle(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  RW'($urandom_range(0, 3)), $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < ready_pct);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_pc_stall", bus.pc_stall_o, 1'b0);
        check("rst_if_id_nop", bus.if_id_nop_o, 1'b0);
        check("rst_id_ex_nop", bus.id_ex_nop_o, 1'b0);
        check("rst_back_hold", bus.back_hold_o, 1'b0);
        check("rst_mem_err", bus.mem_err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // load x5 in EX, ID reads x5: one bubble, then clear
        cycle(5, 0, 1, 0, 5, 1, 0, 0, 0);
        cycle(5, 0, 1, 0, 0, 0, 0, 0, 0);
        // load into x0 never stalls
        cycle(0, 0, 1, 1, 0, 1, 0, 0, 0);
        // redirect outranks load-use
        cycle(7, 7, 0, 1, 7, 1, 1, 0, 0);

        // multi-cycle access, ready after 3 wait cycles, redirect during wait
        hold_seen = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("wait_hold_cycles", hold_seen, 4);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wait_hold_total", hold_seen, 4);

        // timeout: ready never arrives
        hold_seen = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TO + 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("timeout_hold_cycles", hold_seen, TO + 1);
        check("timeout_err_sticky", bus.mem_err_o, 1'b1);

        random_phase(300, 35);
        async_reset("err_clear");

        // async reset mid-wait
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        async_reset("mid_wait");
        cycle(3, 0, 1, 0, 3, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        random_phase(300, 35);
        random_phase(300, 6);
        async_reset("final");
        random_phase(100, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RISC-V pipeline.
- Drives the stall/nop controls of the IF/ID and ID/EX registers, the PC hold, and the back-end freeze.
- Detects load-use hazards, flushes on EX redirects, and holds the pipe during multi-cycle data-memory accesses, with a timeout.

Parameters:
- REG_ADDR_W, 5: register address width.
- MEM_TIMEOUT, 64: max MEM_WAIT cycles before abort (>=2).
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_i  in  REG_ADDR_W  ID rs1 address.
- id_rs2_i  in  REG_ADDR_W  ID rs2 address.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  REG_ADDR_W  EX destination register (0 = none).
- ex_is_load_i  in  1  EX instruction is a load.
- ex_redirect_i  in  1  EX taken branch/jump; PC redirected this cycle.
- mem_req_i  in  1  MEM stage starts a data access.
- mem_ready_i  in  1  data memory completes the access.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- if_id_nop_o  out  1  IF/ID loads NOP.
- id_ex_nop_o  out  1  ID/EX loads bubble (rd=0, no write).
- back_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- mem_err_o  out  1  sticky timeout flag.

Behaviour:
- States: RUN, MEM_WAIT, REPLAY.
- Reset (rst_n=0, async):
  - state=RUN, timeout count=0, redirect_pend=0, mem_err_o=0.
  - All control outputs 0 (combinational from the reset state).
- Control outputs are combinational from state and inputs (0-cycle latency). State, counter, pend and err are registered.
- load_use = ex_is_load_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- RUN, evaluated in priority order:
  - mem_req_i & !mem_ready_i:
    - pc_stall_o=if_id_stall_o=back_hold_o=1.
    - Next state MEM_WAIT, count=1.
    - If ex_redirect_i is also high, set redirect_pend.
  - mem_req_i & mem_ready_i: single-cycle access, treated as no memory event. Go to the next rule.
  - ex_redirect_i: if_id_nop_o=1, id_ex_nop_o=1. The redirect takes priority over load_use.
  - load_use: pc_stall_o=1, if_id_stall_o=1, id_ex_nop_o=1. Exactly one bubble per hazard; the next cycle re-evaluates.
- MEM_WAIT:
  - pc_stall_o=if_id_stall_o=back_hold_o=1; count increments each cycle.
  - Any ex_redirect_i seen here sets redirect_pend.
  - mem_ready_i=1: holds still asserted this cycle, next state REPLAY.
  - mem_ready_i=0 and count==MEM_TIMEOUT: set mem_err_o, next state REPLAY (access abandoned).
  - mem_ready_i has priority over timeout in the same cycle, so no error is raised.
- REPLAY: all holds released for one cycle.
  - redirect_pend=1: if_id_nop_o=id_ex_nop_o=1, then clear pend.
  - Otherwise apply the RUN rules except a new memory wait. A mem_req_i here is accepted only next cycle.
  - Next state RUN.
- mem_err_o clears only on reset.
- Counter saturates at MEM_TIMEOUT and is never wider than $clog2(MEM_TIMEOUT+1).
- ex_rd_i==0 never causes a hazard.
- Reset asserted mid-MEM_WAIT aborts immediately to RUN, with the pend flag cleared.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt_o[CNT_W] (cycles with pc_stall_o=1) and perf_flush_cnt_o[CNT_W] (cycles with id_ex_nop_o from a redirect).
  - Both saturate at all-ones and reset to 0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package pipeline_ctrl_pkg: state enum (RUN, MEM_WAIT, REPLAY), REG_ZERO constant, default MEM_TIMEOUT.
- Sub-module hazard_detect: the combinational load_use compare, reusable for forwarding checks.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 with use=1 -> one cycle of pc_stall_o=if_id_stall_o=id_ex_nop_o=1, then all 0.
- Load into ex_rd_i=0, ID rs1=0 -> no stall.
- Load-use and ex_redirect_i in the same cycle -> if_id_nop_o=id_ex_nop_o=1, pc_stall_o=0.
- mem_req_i=1 with mem_ready_i arriving after 3 cycles:
  - back_hold_o=1 for 4 cycles, then REPLAY, then RUN.
  - mem_err_o=0.
  - A redirect pulsed during the wait produces the nops in the REPLAY cycle.
- mem_req_i with mem_ready_i never asserted, MEM_TIMEOUT=8 -> mem_err_o=1 after 8 wait cycles, holds drop; err stays 1 until rst_n=0.
- rst_n pulsed low mid-MEM_WAIT -> outputs 0 immediately (async), state RUN after release.
